// File: rtl/ibex_lsu_outstanding_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_lsu_pkg
// Description : Shared types for the outstanding-transaction LSU: access size
//               enum, per-beat metadata record and issue FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_lsu_pkg;

  // Wide enough for counts 0..8 plus the two beats a split access adds
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    LSU_WORD   = 2'b00,
    LSU_HALF   = 2'b01,
    LSU_BYTE   = 2'b10,
    LSU_DOUBLE = 2'b11
  } lsu_type_e;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } lsu_state_e;

  // One entry per bus beat (or per PMP-faulted beat) awaiting its response
  typedef struct packed {
    logic [2:0] offset;    // byte offset of the access inside the first bus word
    lsu_type_e  lsu_type;
    logic       sign_ext;
    logic       we;
    logic       split;     // first half of a split access: no core response
    logic       second;    // second half of a split access: merge with hold
    logic       err;       // PMP fault: entry retires without a bus response
  } lsu_meta_t;

endpackage
`default_nettype wire

// File: rtl/ibex_lsu_outstanding_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_lsu_outstanding_if
// Description : Data-bus side of the LSU (request/grant/response plus PMP).
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_lsu_outstanding_if #(
  parameter int DataWidth = 32
);
  logic                     data_req_o;
  logic                     data_gnt_i;
  logic [31:0]              data_addr_o;
  logic                     data_we_o;
  logic [DataWidth/8-1:0]   data_be_o;
  logic [DataWidth-1:0]     data_wdata_o;
  logic                     data_rvalid_i;
  logic [DataWidth-1:0]     data_rdata_i;
  logic                     data_bus_err_i;
  logic                     data_pmp_err_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_bus_err_i, data_pmp_err_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_bus_err_i, data_pmp_err_i
  );
endinterface
`default_nettype wire

// File: rtl/ibex_lsu_meta_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ibex_lsu_meta_fifo
// Description : In-order metadata queue; push and pop may coincide when full.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_lsu_meta_fifo
  import ibex_lsu_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  lsu_meta_t        push_data_i,
  input  logic             pop_i,
  output lsu_meta_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] level_o
);
  localparam int                PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0]   LastPtr = PtrW'(Depth - 1);
  localparam logic [CNT_W-1:0]  DepthC  = CNT_W'(Depth);

  lsu_meta_t        mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             w_push, w_pop;

  // Pointer and level update; a pop frees the slot a same-cycle push uses
  always_comb begin
    w_pop   = pop_i && (level_q != '0);
    w_push  = push_i && ((level_q != DepthC) || w_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (w_push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    if (w_pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    if (w_push && !w_pop)      level_d = level_q + 1'b1;
    else if (!w_push && w_pop) level_d = level_q - 1'b1;
  end

  // Control state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only read while the level covers them
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (level_q == DepthC);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/ibex_lsu_outstanding.sv
`default_nettype none
// ============================================================================
// Module      : ibex_lsu_outstanding
// Description : LSU with several granted-but-unanswered bus beats, split
//               handling of misaligned accesses and in-order responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_lsu_outstanding
  import ibex_lsu_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [1:0]           lsu_type_i,
  input  logic                 lsu_sign_ext_i,
  input  logic [31:0]          lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_req_done_o,
  output logic                 lsu_resp_valid_o,
  output logic [DataWidth-1:0] lsu_rdata_o,
  output logic                 load_err_o,
  output logic                 store_err_o,
  output logic                 busy_o,
  output logic                 perf_load_o,
  output logic                 perf_store_o,
  ibex_lsu_outstanding_if.master bus
);
  localparam int               NB    = DataWidth / 8;
  localparam int               OffW  = $clog2(NB);
  localparam logic [CNT_W-1:0] MaxC  = CNT_W'(MaxOutstanding);

  lsu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    pmp_cnt_q, pmp_cnt_d;
  logic [DataWidth-1:0] hold_q, hold_d;
  logic                hold_err_q, hold_err_d;

  logic                w_req, w_split, w_room, w_push, w_pop, w_accept, w_grant, w_rvalid;
  logic [2:0]          w_off;
  logic [2*NB-1:0]     w_mask, w_be_all;
  logic [CNT_W-1:0]    w_beats, w_level;
  logic [6:0]          w_wsh;
  lsu_meta_t           w_push_meta, w_head;
  logic                w_full, w_empty, w_err;
  logic [2*DataWidth-1:0] w_merged;
  logic [DataWidth-1:0] w_shifted, w_ext, w_low_mask;
  logic                w_sign;

  // Reset forces every handshake output low while address/be/wdata stay live
  assign w_req    = lsu_req_i & ~rst_i;
  assign w_off    = 3'(lsu_addr_i[OffW-1:0]);
  assign w_wsh    = {1'b0, w_off, 3'b000};
  assign w_be_all = w_mask << w_off;
  assign w_split  = |w_be_all[2*NB-1:NB];
  assign w_beats  = w_split ? CNT_W'(2) : CNT_W'(1);
  // The PMP-entry guard keeps a faulted entry from sharing a cycle with a bus rvalid
  assign w_room   = ((count_q + w_beats) <= MaxC) && ((w_level + w_beats) <= MaxC) &&
                    (pmp_cnt_q == '0);

  // Byte-enable pattern of the access before rotation into lanes
  always_comb begin
    w_mask = '0;
    unique case (lsu_type_i)
      2'b10:   w_mask = (2*NB)'(8'h01);
      2'b01:   w_mask = (2*NB)'(8'h03);
      2'b00:   w_mask = (2*NB)'(8'h0F);
      default: w_mask = (2*NB)'(8'hFF);
    endcase
  end

  assign bus.data_addr_o  = {lsu_addr_i[31:OffW], {OffW{1'b0}}} +
                            ((state_q == ST_SECOND) ? 32'(NB) : 32'd0);
  assign bus.data_be_o    = (state_q == ST_SECOND) ? w_be_all[2*NB-1:NB] : w_be_all[NB-1:0];
  assign bus.data_wdata_o = (lsu_wdata_i << w_wsh) | (lsu_wdata_i >> (7'(DataWidth) - w_wsh));
  assign bus.data_we_o    = lsu_we_i & ~rst_i;
  assign w_grant          = bus.data_req_o & bus.data_gnt_i;

  // Issue FSM: next state, bus request and metadata push
  always_comb begin
    state_d              = state_q;
    bus.data_req_o       = 1'b0;
    lsu_req_done_o       = 1'b0;
    w_push               = 1'b0;
    w_accept             = 1'b0;
    w_push_meta          = '0;
    w_push_meta.offset   = w_off;
    w_push_meta.lsu_type = lsu_type_e'(lsu_type_i);
    w_push_meta.sign_ext = lsu_sign_ext_i;
    w_push_meta.we       = lsu_we_i;
    unique case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          if (bus.data_pmp_err_i) begin
            if (!w_full) begin
              w_push          = 1'b1;
              w_push_meta.err = 1'b1;
              lsu_req_done_o  = 1'b1;
              w_accept        = 1'b1;
            end
          end else if (w_room) begin
            bus.data_req_o = 1'b1;
            if (bus.data_gnt_i) begin
              w_push            = 1'b1;
              w_push_meta.split = w_split;
              w_accept          = 1'b1;
              if (w_split) state_d = ST_SECOND;
              else         lsu_req_done_o = 1'b1;
            end
          end
        end
      end
      ST_SECOND: begin
        w_push_meta.second = 1'b1;
        if (bus.data_pmp_err_i) begin
          w_push          = 1'b1;
          w_push_meta.err = 1'b1;
          lsu_req_done_o  = 1'b1;
          state_d         = ST_IDLE;
        end else begin
          bus.data_req_o = 1'b1;
          if (bus.data_gnt_i) begin
            w_push         = 1'b1;
            lsu_req_done_o = 1'b1;
            state_d        = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign perf_load_o  = w_accept & ~lsu_we_i;
  assign perf_store_o = w_accept & lsu_we_i;

  ibex_lsu_meta_fifo #(
    .Depth (MaxOutstanding)
  ) u_meta_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_push_meta),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (w_level)
  );

  // Response side: retire the head, track counts and the split-half holding register
  always_comb begin
    w_rvalid   = bus.data_rvalid_i && (count_q != '0);
    w_pop      = !w_empty && (w_head.err || w_rvalid);
    count_d    = count_q;
    if (w_grant && !w_rvalid)      count_d = count_q + 1'b1;
    else if (!w_grant && w_rvalid) count_d = count_q - 1'b1;
    pmp_cnt_d  = pmp_cnt_q;
    if ((w_push && w_push_meta.err) && !(w_pop && w_head.err))      pmp_cnt_d = pmp_cnt_q + 1'b1;
    else if (!(w_push && w_push_meta.err) && (w_pop && w_head.err)) pmp_cnt_d = pmp_cnt_q - 1'b1;
    hold_d     = hold_q;
    hold_err_d = hold_err_q;
    if (w_pop && w_head.split) begin
      hold_d     = bus.data_rdata_i;
      hold_err_d = bus.data_bus_err_i | w_head.err;
    end
  end

  // Load data: merge halves, shift the addressed bytes down, then extend
  always_comb begin
    w_merged   = w_head.second ? {bus.data_rdata_i, hold_q} : {{DataWidth{1'b0}}, bus.data_rdata_i};
    w_shifted  = DataWidth'(w_merged >> {w_head.offset, 3'b000});
    w_low_mask = '1;
    w_sign     = w_shifted[DataWidth-1];
    unique case (w_head.lsu_type)
      LSU_BYTE: begin w_low_mask = DataWidth'(8'hFF);         w_sign = w_shifted[7];  end
      LSU_HALF: begin w_low_mask = DataWidth'(16'hFFFF);      w_sign = w_shifted[15]; end
      LSU_WORD: begin w_low_mask = DataWidth'(32'hFFFF_FFFF); w_sign = w_shifted[31]; end
      default:  begin w_low_mask = '1; w_sign = w_shifted[DataWidth-1]; end
    endcase
    w_ext = w_shifted & w_low_mask;
    if (w_head.sign_ext && w_sign) w_ext = w_ext | ~w_low_mask;
  end

  assign w_err            = w_head.err | (w_rvalid & bus.data_bus_err_i) | (w_head.second & hold_err_q);
  assign lsu_resp_valid_o = w_pop && !w_head.split;
  assign lsu_rdata_o      = (lsu_resp_valid_o && !w_head.we) ? w_ext : '0;
  assign load_err_o       = lsu_resp_valid_o & w_err & ~w_head.we;
  assign store_err_o      = lsu_resp_valid_o & w_err & w_head.we;
  assign busy_o           = (state_q != ST_IDLE) || !w_empty;

  // State, counters and holding register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      pmp_cnt_q  <= '0;
      hold_q     <= '0;
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pmp_cnt_q  <= pmp_cnt_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_lsu_outstanding.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_lsu_outstanding
// Description : Directed self-checking bench for ibex_lsu_outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_lsu_outstanding;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_req_done_o, lsu_resp_valid_o, load_err_o, store_err_o;
  logic        busy_o, perf_load_o, perf_store_o;
  logic [31:0] lsu_rdata_o;
  int          n_total = 0;
  int          n_bad   = 0;

  ibex_lsu_outstanding_if #(.DataWidth(32)) bus ();

  ibex_lsu_outstanding #(.DataWidth(32), .MaxOutstanding(2)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_type_i       (lsu_type_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_req_done_o   (lsu_req_done_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_rdata_o      (lsu_rdata_o),
    .load_err_o       (load_err_o),
    .store_err_o      (store_err_o),
    .busy_o           (busy_o),
    .perf_load_o      (perf_load_o),
    .perf_store_o     (perf_store_o),
    .bus              (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic core_req(input logic req, input logic we, input logic [1:0] typ,
                          input logic sx, input logic [31:0] addr, input logic [31:0] wd);
    lsu_req_i = req; lsu_we_i = we; lsu_type_i = typ;
    lsu_sign_ext_i = sx; lsu_addr_i = addr; lsu_wdata_i = wd;
  endtask

  task automatic bus_drv(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic berr, input logic perr);
    bus.data_gnt_i = gnt; bus.data_rvalid_i = rv; bus.data_rdata_i = rd;
    bus.data_bus_err_i = berr; bus.data_pmp_err_i = perr;
  endtask

  initial begin
    rst_i = 1'b1;
    core_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h1122_3344);
    bus_drv(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    #2;
    // Reset: handshakes quiet, address/be/wdata follow the inputs
    check_eq("rst_req",   bus.data_req_o, 0);
    check_eq("rst_done",  lsu_req_done_o, 0);
    check_eq("rst_resp",  lsu_resp_valid_o, 0);
    check_eq("rst_busy",  busy_o, 0);
    check_eq("rst_we",    bus.data_we_o, 0);
    check_eq("rst_perf",  perf_store_o, 0);
    check_eq("rst_addr",  bus.data_addr_o, 32'h100);
    check_eq("rst_be",    bus.data_be_o, 4'b1000);
    check_eq("rst_wdata", bus.data_wdata_o, 32'h4411_2233);
    tick();
    rst_i = 1'b0;
    core_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    // Word load at 0x100, response two cycles after grant
    core_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("wl_req",  bus.data_req_o, 1);
    check_eq("wl_addr", bus.data_addr_o, 32'h100);
    check_eq("wl_be",   bus.data_be_o, 4'hF);
    check_eq("wl_done", lsu_req_done_o, 1);
    check_eq("wl_perf", perf_load_o, 1);
    tick();
    core_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("wl_busy", busy_o, 1);
    check_eq("wl_noresp", lsu_resp_valid_o, 0);
    tick();
    bus_drv(1'b0, 1'b1, 32'h8000_00FF, 1'b0, 1'b0);
    #1;
    check_eq("wl_resp",  lsu_resp_valid_o, 1);
    check_eq("wl_rdata", lsu_rdata_o, 32'h8000_00FF);
    check_eq("wl_err",   load_err_o, 0);
    tick();
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("wl_idle", busy_o, 0);

    // Signed half load at 0x103: split into two beats
    tick();
    core_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h103, 32'h0);
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("sh_req1",  bus.data_req_o, 1);
    check_eq("sh_addr1", bus.data_addr_o, 32'h100);
    check_eq("sh_be1",   bus.data_be_o, 4'b1000);
    check_eq("sh_done1", lsu_req_done_o, 0);
    tick();
    #1;
    check_eq("sh_req2",  bus.data_req_o, 1);
    check_eq("sh_addr2", bus.data_addr_o, 32'h104);
    check_eq("sh_be2",   bus.data_be_o, 4'b0001);
    check_eq("sh_done2", lsu_req_done_o, 1);
    tick();
    core_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_drv(1'b0, 1'b1, 32'h3400_0000, 1'b0, 1'b0);
    #1;
    check_eq("sh_half1", lsu_resp_valid_o, 0);
    tick();
    bus_drv(1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    #1;
    check_eq("sh_resp",  lsu_resp_valid_o, 1);
    check_eq("sh_rdata", lsu_rdata_o, 32'hFFFF_8034);
    tick();
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Three byte loads against a limit of two outstanding beats
    core_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("bl_a_done", lsu_req_done_o, 1);
    tick();
    core_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h201, 32'h0);
    #1;
    check_eq("bl_b_done", lsu_req_done_o, 1);
    tick();
    core_req(1'b1, 1'b0, 2'b10, 1'b1, 32'h203, 32'h0);
    #1;
    check_eq("bl_c_stall0", bus.data_req_o, 0);
    tick();
    #1;
    check_eq("bl_c_stall1", bus.data_req_o, 0);
    tick();
    bus_drv(1'b1, 1'b1, 32'h0000_00AB, 1'b0, 1'b0);
    #1;
    check_eq("bl_a_resp",  lsu_resp_valid_o, 1);
    check_eq("bl_a_rdata", lsu_rdata_o, 32'hAB);
    check_eq("bl_c_stall2", bus.data_req_o, 0);
    tick();
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("bl_c_req", bus.data_req_o, 1);
    check_eq("bl_c_be",  bus.data_be_o, 4'b1000);
    tick();
    core_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_drv(1'b0, 1'b1, 32'h0000_CD00, 1'b0, 1'b0);
    #1;
    check_eq("bl_b_rdata", lsu_rdata_o, 32'hCD);
    tick();
    bus_drv(1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    #1;
    check_eq("bl_c_resp",  lsu_resp_valid_o, 1);
    check_eq("bl_c_rdata", lsu_rdata_o, 32'hFFFF_FF80);
    tick();
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("bl_idle", busy_o, 0);

    // Outstanding load, then a PMP-faulted store behind it
    core_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h300, 32'h0);
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    core_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h304, 32'h5555_5555);
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    check_eq("pmp_noreq", bus.data_req_o, 0);
    check_eq("pmp_done",  lsu_req_done_o, 1);
    check_eq("pmp_perf",  perf_store_o, 1);
    tick();
    core_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("pmp_wait", lsu_resp_valid_o, 0);
    tick();
    bus_drv(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    #1;
    check_eq("pmp_ld_resp",  lsu_resp_valid_o, 1);
    check_eq("pmp_ld_rdata", lsu_rdata_o, 32'h1234_5678);
    check_eq("pmp_ld_serr",  store_err_o, 0);
    tick();
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("pmp_st_resp",  lsu_resp_valid_o, 1);
    check_eq("pmp_st_serr",  store_err_o, 1);
    check_eq("pmp_st_lerr",  load_err_o, 0);
    check_eq("pmp_st_rdata", lsu_rdata_o, 32'h0);
    tick();
    #1;
    check_eq("pmp_idle", busy_o, 0);

    // Split word store at 0x2 with a bus error on the first half
    core_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h2, 32'hAABB_CCDD);
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("ss_be1",    bus.data_be_o, 4'b1100);
    check_eq("ss_wdata",  bus.data_wdata_o, 32'hCCDD_AABB);
    check_eq("ss_we",     bus.data_we_o, 1);
    tick();
    #1;
    check_eq("ss_addr2",  bus.data_addr_o, 32'h4);
    check_eq("ss_be2",    bus.data_be_o, 4'b0011);
    tick();
    core_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_drv(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    #1;
    check_eq("ss_half1", lsu_resp_valid_o, 0);
    tick();
    bus_drv(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("ss_resp", lsu_resp_valid_o, 1);
    check_eq("ss_serr", store_err_o, 1);
    tick();
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset with two beats outstanding; later rvalids must be ignored
    core_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
    bus_drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    core_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h404, 32'h0);
    tick();
    core_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("rr_busy_pre", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check_eq("rr_busy_rst", busy_o, 0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      #1;
      check_eq("rr_noresp", lsu_resp_valid_o, 0);
      check_eq("rr_busy",   busy_o, 0);
      tick();
    end
    bus_drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibex_lsu_outstanding.md
IBEX_LSU_OUTSTANDING -- requirements
Module: ibex_lsu_outstanding

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning bus data width; legal values are 32 and 64.
REQ-002 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted bus transactions not yet responded to; legal range is 1..8.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- lsu_req_i, in, 1, core request; lsu_we_i, lsu_type_i, lsu_sign_ext_i, lsu_addr_i and lsu_wdata_i are held stable until lsu_req_done_o.
- lsu_we_i, in, 1, store.
- lsu_type_i, in, 2, access size: 00 word, 01 half, 10 byte, 11 double (11 is legal only when DataWidth=64).
- lsu_sign_ext_i, in, 1, sign-extend load data.
- lsu_addr_i, in, 32, byte address.
- lsu_wdata_i, in, DataWidth, store data.
- lsu_req_done_o, out, 1, request fully issued.
- data_req_o, out, 1, bus request.
- data_gnt_i, in, 1, bus grant.
- data_addr_o, out, 32, bus-word-aligned address.
- data_we_o, out, 1, bus write.
- data_be_o, out, DataWidth/8, byte enables.
- data_wdata_o, out, DataWidth, rotated store data.
- data_rvalid_i, in, 1, bus response.
- data_rdata_i, in, DataWidth, bus read data.
- data_bus_err_i, in, 1, bus error qualifying rvalid.
- data_pmp_err_i, in, 1, PMP fault for the current request.
- lsu_resp_valid_o, out, 1, response for the oldest request.
- lsu_rdata_o, out, DataWidth, extended load data.
- load_err_o, out, 1, load error qualifying resp.
- store_err_o, out, 1, store error qualifying resp.
- busy_o, out, 1, unit busy.
- perf_load_o, out, 1, load accepted pulse.
- perf_store_o, out, 1, store accepted pulse.

Function
REQ-005 Issue FSM SHALL have states IDLE and SECOND; an access crossing a DataWidth/8-byte boundary is split into two bus beats.
REQ-006 In IDLE with lsu_req_i, data_req_o SHALL assert only if the outstanding count plus the beats needed is at most MaxOutstanding and data_pmp_err_i=0.
REQ-007 On grant in IDLE, first-beat metadata (offset, type, sign_ext, we, split flag, err=0) SHALL be pushed; an unsplit access asserts lsu_req_done_o in the same cycle; a split access goes to SECOND.
REQ-008 SECOND SHALL drive data_req_o=1 at aligned address+DataWidth/8 with the upper-part byte enables; on grant it pushes metadata, asserts lsu_req_done_o and returns to IDLE.
REQ-009 A PMP error in IDLE SHALL issue no bus beat, SHALL push one entry with err=1 and assert lsu_req_done_o; a PMP error in SECOND SHALL mark the request as errored and suppress the second beat.
REQ-010 Responses SHALL be returned strictly in order; the head entry pops on data_rvalid_i, or without rvalid when it is a PMP-error entry.
REQ-011 A split first-half response SHALL produce no lsu_resp_valid_o; it latches rdata and its error, and the second half merges both and ORs the errors.
REQ-012 Outstanding count SHALL be +1 on grant and -1 on rvalid, unchanged when both occur in the same cycle; rvalid while count=0 is ignored.
REQ-013 Load extension SHALL select bytes from offset and size, zero- or sign-extend to DataWidth, and drive zero on store responses.
REQ-014 load_err_o and store_err_o SHALL equal the entry error qualified by lsu_resp_valid_o and we.
REQ-015 perf_load_o / perf_store_o SHALL pulse exactly once per accepted request, at the first grant or the PMP completion.
REQ-016 busy_o SHALL be high when the state is not IDLE or the metadata FIFO is non-empty.
REQ-017 lsu_resp_valid_o SHALL be combinational from data_rvalid_i: zero added latency.

Reset
REQ-018 While rst_i=1: state IDLE, FIFO empty, count 0, holding register 0; every output is 0 except data_addr_o, data_be_o and data_wdata_o, which follow their inputs combinationally.
REQ-019 Reset mid-transaction SHALL discard all in-flight metadata; later rvalids are ignored per REQ-012.

Structure
REQ-020 Package ibex_lsu_pkg SHALL hold the lsu_type_e enum, the metadata struct and the FSM state enum.
REQ-021 The metadata queue SHALL be a sub-module ibex_lsu_meta_fifo with depth MaxOutstanding, push/pop/full/empty, and simultaneous push and pop allowed when full.

Verification
REQ-022 Word load at 0x100, gnt on cycle 0, rvalid on cycle 2 with rdata 0x8000_00FF -> resp on cycle 2, rdata 0x8000_00FF, no error.
REQ-023 Signed half load at 0x103 (DataWidth=32), mem bytes 0x103=0x34 and 0x104=0x80 -> two beats (be 1000, then 0001), one resp with rdata 0xFFFF_8034.
REQ-024 MaxOutstanding=2, three back-to-back byte loads, rvalid delayed -> third request is stalled (data_req_o=0) until the first rvalid arrives.
REQ-025 Outstanding word load, then a store with data_pmp_err_i=1 -> no bus beat for the store; its store_err_o resp appears only after the load resp.
REQ-026 Split word store at 0x2 with data_bus_err_i on the first half -> one resp with store_err_o=1.
REQ-027 rst_i asserted with 2 outstanding, then 2 rvalids -> no lsu_resp_valid_o, busy_o=0.
